// File: rtl/data_memory_ws_pkg.sv
// Shared encodings, FSM states and lane helpers for the wait-state data memory.
// Lane and extension helpers work on 64-bit values; callers truncate to DATA_WIDTH.
package data_memory_ws_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    localparam int CTRL_WR = 2;
    localparam int CTRL_RD = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte-enable pattern for an access of the given size, anchored at lane 0.
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SIZE_BYTE: m = 8'h01;
            SIZE_HALF: m = 8'h03;
            SIZE_WORD: m = 8'h0F;
            default:   m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                           input logic sgn);
        logic [63:0] r;
        case (size)
            SIZE_BYTE: r = {{56{sgn & raw[7]}}, raw[7:0]};
            SIZE_HALF: r = {{48{sgn & raw[15]}}, raw[15:0]};
            SIZE_WORD: r = {{32{sgn & raw[31]}}, raw[31:0]};
            default:   r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_memory_ws_if.sv
// CPU data-bus bundle between the CPU (master) and the wait-state memory (slave).
// Handshake: master raises ControlBus[2] or [1] as its request; the slave samples it only
// when idle, ignores the bus while Busy, and answers with one MemReady pulse (MemFault qualifies it).
interface data_memory_ws_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] AddressBus;
    logic [DATA_WIDTH-1:0] DataBusOut;
    logic [2:0]            ControlBus;
    logic [1:0]            SizeSel;
    logic                  SignedLoad;
    logic [DATA_WIDTH-1:0] DataBusIn;
    logic                  MemReady;
    logic                  MemFault;
    logic                  Busy;
    logic [CNT_WIDTH-1:0]  ReadCount;
    logic [CNT_WIDTH-1:0]  WriteCount;
    logic [CNT_WIDTH-1:0]  FaultCount;

    modport master (
        output AddressBus, DataBusOut, ControlBus, SizeSel, SignedLoad,
        input  DataBusIn, MemReady, MemFault, Busy, ReadCount, WriteCount, FaultCount
    );

    modport slave (
        input  AddressBus, DataBusOut, ControlBus, SizeSel, SignedLoad,
        output DataBusIn, MemReady, MemFault, Busy, ReadCount, WriteCount, FaultCount
    );
endinterface

// File: rtl/data_memory_ws_dmem_array.sv
// DEPTH x DATA_WIDTH synchronous RAM with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                    clk,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    we,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        // Indices past DEPTH only occur on requests that will fault; hold the old value.
        if (32'(rd_idx) < DEPTH) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/data_memory_ws.sv
// Wait-state data memory: latches one request, waits LATENCY cycles, checks faults, steers
// byte lanes into dmem_array, extends loads, and keeps saturating access counters.
module data_memory_ws
    import data_memory_ws_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic            InputClk,
    input  logic            rst,
    data_memory_ws_if.slave bus,
    output state_e          dbg_state
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFF_W    = $clog2(BYTES);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit DWORD_OK = (DATA_WIDTH == 64);

    state_e                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]  flt_cnt_q, flt_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Fault qualification on the latched request.
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [2:0]            align_mask;
    logic                  misaligned, range_bad, dword_bad, both_bad, fault;

    always_comb begin
        word_idx = addr_q >> OFF_W;
        case (size_q)
            SIZE_BYTE: align_mask = 3'b000;
            SIZE_HALF: align_mask = 3'b001;
            SIZE_WORD: align_mask = 3'b011;
            default:   align_mask = 3'b111;
        endcase
        misaligned = (addr_q[2:0] & align_mask) != 3'b000;
        range_bad  = word_idx >= ADDR_WIDTH'(DEPTH);
        dword_bad  = (size_q == SIZE_DWORD) && !DWORD_OK;
        both_bad   = wr_q && rd_q;
        fault      = both_bad | misaligned | range_bad | dword_bad;
    end

    // Lane steering and array addressing.
    logic [OFF_W-1:0]      lane_off;
    logic [OFF_W+2:0]      bit_off;
    logic [7:0]            mask8;
    logic [BYTES-1:0]      be;
    logic [DATA_WIDTH-1:0] wr_lanes, rd_data, rd_shift;
    logic [63:0]           rd_wide, ext;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic                  access_now, mem_we;

    always_comb begin
        lane_off   = addr_q[OFF_W-1:0];
        bit_off    = {lane_off, 3'b000};
        mask8      = lane_mask(size_q);
        be         = mask8[BYTES-1:0] << lane_off;
        wr_lanes   = wdata_q << bit_off;
        rd_shift   = rd_data >> bit_off;
        rd_wide    = '0;
        rd_wide[DATA_WIDTH-1:0] = rd_shift;
        ext        = extend(rd_wide, size_q, sgn_q);
        wr_idx     = IDX_W'(word_idx);
        // While idle the RAM is addressed straight from the bus so that read data is
        // already registered by the time a LATENCY=1 access completes.
        rd_idx     = (state_q == ST_IDLE) ? IDX_W'(bus.AddressBus >> OFF_W) : wr_idx;
        access_now = (state_q == ST_WAIT) && (wait_q == 4'd0);
        mem_we     = access_now && wr_q && !fault && !rst;
    end

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (InputClk),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .we      (mem_we),
        .wr_idx  (wr_idx),
        .be      (be),
        .wdata   (wr_lanes)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        dout_d    = dout_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        flt_cnt_d = flt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ControlBus[CTRL_WR] || bus.ControlBus[CTRL_RD]) begin
                    addr_d  = bus.AddressBus;
                    wdata_d = bus.DataBusOut;
                    size_d  = bus.SizeSel;
                    sgn_d   = bus.SignedLoad;
                    wr_d    = bus.ControlBus[CTRL_WR];
                    rd_d    = bus.ControlBus[CTRL_RD];
                    wait_d  = 4'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_DONE;
                    if (fault) begin
                        flt_cnt_d = sat_inc(flt_cnt_q);
                    end else if (rd_q) begin
                        dout_d   = ext[DATA_WIDTH-1:0];
                        rd_cnt_d = sat_inc(rd_cnt_q);
                    end else begin
                        wr_cnt_d = sat_inc(wr_cnt_q);
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge InputClk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            dout_q    <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            flt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            dout_q    <= dout_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign bus.DataBusIn  = dout_q;
    assign bus.MemReady   = (state_q == ST_DONE);
    assign bus.MemFault   = (state_q == ST_DONE) && fault;
    assign bus.Busy       = (state_q == ST_WAIT);
    assign bus.ReadCount  = rd_cnt_q;
    assign bus.WriteCount = wr_cnt_q;
    assign bus.FaultCount = flt_cnt_q;
    assign dbg_state      = state_q;

    // Reserved control bit and the unused upper lane/extension bits.
    logic unused_bits;
    assign unused_bits = ^{bus.ControlBus[0], ext, mask8};
endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws: a 32-bit unit (LATENCY=3, DEPTH=16) and a 64-bit unit
// (LATENCY=2, DEPTH=16, 4-bit counters) checked against a byte-array reference model.
module tb_data_memory_ws;
    import data_memory_ws_pkg::*;

    localparam int LAT_A = 3;
    localparam int LAT_B = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst_a, rst_b;
    state_e st_a, st_b;

    data_memory_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(32)) bus_a ();
    data_memory_ws_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .CNT_WIDTH(4))  bus_b ();

    data_memory_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT_A),
                     .CNT_WIDTH(32)) dut_a (
        .InputClk (clk), .rst (rst_a), .bus (bus_a), .dbg_state (st_a)
    );
    data_memory_ws #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT_B),
                     .CNT_WIDTH(4)) dut_b (
        .InputClk (clk), .rst (rst_b), .bus (bus_b), .dbg_state (st_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: byte-addressed memory, counters and last load per unit.
    logic [7:0]  mem_m [2][DEPTH*8];
    logic [63:0] rc_m [2], wc_m [2], fc_m [2], dout_m [2];
    logic [63:0] cmax [2];

    logic        o_ready, o_fault, o_busy;
    logic [63:0] o_dout, o_rc, o_wc, o_fc;
    state_e      o_st;
    logic [63:0] p_dout, p_rc, p_wc, p_fc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sample(input int u);
        if (u == 0) begin
            o_ready = bus_a.MemReady;  o_fault = bus_a.MemFault;  o_busy = bus_a.Busy;
            o_dout  = 64'(bus_a.DataBusIn);
            o_rc = 64'(bus_a.ReadCount); o_wc = 64'(bus_a.WriteCount); o_fc = 64'(bus_a.FaultCount);
            o_st = st_a;
        end else begin
            o_ready = bus_b.MemReady;  o_fault = bus_b.MemFault;  o_busy = bus_b.Busy;
            o_dout  = bus_b.DataBusIn;
            o_rc = 64'(bus_b.ReadCount); o_wc = 64'(bus_b.WriteCount); o_fc = 64'(bus_b.FaultCount);
            o_st = st_b;
        end
    endtask

    task automatic drive(input int u, input logic [31:0] addr, input logic [63:0] data,
                         input logic [2:0] ctrl, input logic [1:0] size, input logic sgn);
        if (u == 0) begin
            bus_a.AddressBus = addr; bus_a.DataBusOut = data[31:0]; bus_a.ControlBus = ctrl;
            bus_a.SizeSel = size;    bus_a.SignedLoad = sgn;
        end else begin
            bus_b.AddressBus = addr; bus_b.DataBusOut = data;       bus_b.ControlBus = ctrl;
            bus_b.SizeSel = size;    bus_b.SignedLoad = sgn;
        end
    endtask

    task automatic wait_idle(input int u);
        int n;
        n = 0;
        sample(u);
        while (o_st != ST_IDLE && n < 40) begin
            @(negedge clk);
            sample(u);
            n++;
        end
        check("idle_wait", 64'(o_st), 64'(ST_IDLE));
    endtask

    function automatic logic [63:0] sat(input logic [63:0] c, input logic [63:0] mx);
        return (c >= mx) ? mx : c + 64'd1;
    endfunction

    // One complete transaction with timing, data, fault and counter checks.
    task automatic access(input int u, input logic [31:0] addr, input logic [63:0] data,
                          input logic wr, input logic rd, input logic [1:0] size, input logic sgn);
        int          n, lat, nb, bw;
        logic        flt;
        logic [63:0] v;
        lat = (u == 0) ? LAT_A : LAT_B;
        bw  = (u == 0) ? 4 : 8;
        nb  = 1 << size;
        flt = (wr && rd) || (addr % nb != 0) || (size == SIZE_DWORD && bw == 4) ||
              (addr / bw >= DEPTH);
        if (!flt && wr) begin
            for (int i = 0; i < nb; i++) mem_m[u][addr + i] = data[8*i +: 8];
            wc_m[u] = sat(wc_m[u], cmax[u]);
        end else if (!flt) begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[u][addr + i];
            if (sgn && v[8*nb - 1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
            if (bw == 4) v[63:32] = '0;
            dout_m[u] = v;
            rc_m[u]   = sat(rc_m[u], cmax[u]);
        end else begin
            fc_m[u] = sat(fc_m[u], cmax[u]);
        end

        wait_idle(u);
        drive(u, addr, data, {wr, rd, 1'($urandom_range(0, 1))}, size, sgn);
        @(negedge clk);
        // Junk on the bus while busy must be ignored.
        drive(u, $urandom, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        sample(u);
        check("busy_wait", 64'(o_busy), 64'd1);
        n = 0;
        while (!o_ready && n < 40) begin
            @(negedge clk);
            sample(u);
            n++;
        end
        drive(u, 0, 0, 3'b000, SIZE_BYTE, 1'b0);
        check("latency", 64'(n), 64'(lat));
        check("fault", 64'(o_fault), 64'(flt));
        check("busy_done", 64'(o_busy), 64'd0);
        check("dout", o_dout, dout_m[u]);
        p_dout = o_dout;
        @(negedge clk);
        sample(u);
        check("ready_pulse", 64'(o_ready), 64'd0);
        check("rd_cnt", o_rc, rc_m[u]);
        check("wr_cnt", o_wc, wc_m[u]);
        check("flt_cnt", o_fc, fc_m[u]);
        p_rc = o_rc; p_wc = o_wc; p_fc = o_fc;
    endtask

    task automatic check_reset(input int u);
        sample(u);
        check("rst_dout", o_dout, 64'd0);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_fault", 64'(o_fault), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_rc", o_rc, 64'd0);
        check("rst_wc", o_wc, 64'd0);
        check("rst_fc", o_fc, 64'd0);
        check("rst_state", 64'(o_st), 64'(ST_IDLE));
        rc_m[u] = 0; wc_m[u] = 0; fc_m[u] = 0; dout_m[u] = 0;
    endtask

    initial begin
        int u, r, seen;
        logic [1:0] sz;
        cmax[0] = 64'hFFFF_FFFF;
        cmax[1] = 64'hF;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 0, 0, 3'b000, SIZE_BYTE, 1'b0);
        drive(1, 0, 0, 3'b000, SIZE_BYTE, 1'b0);
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Word round trip.
        access(0, 32'h10, 64'hDEADBEEF, 1'b1, 1'b0, SIZE_WORD, 1'b0);
        access(0, 32'h10, 64'h0, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        check("t1_word", p_dout, 64'hDEADBEEF);
        check("t1_wc", p_wc, 64'd1);
        check("t1_rc", p_rc, 64'd1);

        // Byte store, signed and unsigned byte loads.
        access(0, 32'h11, 64'h80, 1'b1, 1'b0, SIZE_BYTE, 1'b0);
        access(0, 32'h11, 64'h0, 1'b0, 1'b1, SIZE_BYTE, 1'b1);
        check("t2_signed", p_dout, 64'hFFFFFF80);
        access(0, 32'h11, 64'h0, 1'b0, 1'b1, SIZE_BYTE, 1'b0);
        check("t2_unsigned", p_dout, 64'h00000080);
        access(0, 32'h10, 64'h0, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        check("t2_word", p_dout, 64'hDEAD80EF);

        // Misaligned half and read+write together both fault; array untouched.
        access(0, 32'h13, 64'h0, 1'b0, 1'b1, SIZE_HALF, 1'b0);
        access(0, 32'h10, 64'h12345678, 1'b1, 1'b1, SIZE_WORD, 1'b0);
        check("t3_fc", p_fc, 64'd2);
        access(0, 32'h10, 64'h0, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        check("t3_word", p_dout, 64'hDEAD80EF);

        // Out-of-range word and dword on a 32-bit bus.
        access(0, 32'h40, 64'h0, 1'b0, 1'b1, SIZE_WORD, 1'b0);
        access(0, 32'h08, 64'h0, 1'b0, 1'b1, SIZE_DWORD, 1'b0);
        check("t4_fc", p_fc, 64'd4);

        for (int w = 0; w < DEPTH; w++) access(0, 32'(w * 4), 64'($urandom), 1'b1, 1'b0, SIZE_WORD, 1'b0);
        for (int w = 0; w < DEPTH; w++) access(1, 32'(w * 8), {$urandom, $urandom}, 1'b1, 1'b0, SIZE_DWORD, 1'b0);

        // Reset while the write of 0x55 to 0x20 is waiting for its last cycle.
        wait_idle(0);
        drive(0, 32'h20, 64'h55, 3'b100, SIZE_WORD, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, SIZE_BYTE, 1'b0);
        repeat (2) @(negedge clk);
        sample(0);
        check("t5_busy", 64'(o_busy), 64'd1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_reset(0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            sample(0);
            if (o_ready) seen = 1;
        end
        check("t5_no_ready", 64'(seen), 64'd0);
        access(0, 32'h20, 64'h0, 1'b0, 1'b1, SIZE_WORD, 1'b0);

        // Dword round trip on the 64-bit unit.
        access(1, 32'h08, 64'h0123456789ABCDEF, 1'b1, 1'b0, SIZE_DWORD, 1'b0);
        access(1, 32'h08, 64'h0, 1'b0, 1'b1, SIZE_DWORD, 1'b0);
        check("t4_dword", p_dout, 64'h0123456789ABCDEF);

        // 4-bit counters saturate.
        for (int i = 0; i < 20; i++) access(1, 32'(8 * $urandom_range(0, DEPTH - 1)), 64'h0, 1'b0, 1'b1, SIZE_WORD, 1'b1);
        check("t6_rc_sat", p_rc, 64'hF);

        for (int i = 0; i < 160; i++) begin
            u  = $urandom_range(0, 1);
            r  = $urandom_range(0, 9);
            sz = 2'($urandom_range(0, 3));
            access(u, 32'($urandom_range(0, DEPTH * ((u == 0) ? 4 : 8) + 15)),
                   {$urandom, $urandom}, (r < 5), (r == 0 || r >= 5), sz,
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
